accum_diff_split: RTL and testbench
===================================

Name: accum_diff_split

Overview:
- Decoder paired with the team's two-lane interleaved accumulator.
- Consumes a stream of 40-bit running sums whose beats alternate lane 0 / lane 1.
- Recovers each lane's original 32-bit input sample by differencing against that lane's previous sum.
- Emits the recovered samples on a registered valid/ready output with a lane tag and a range-error flag.

Parameters:
- ACC_W, 40, width of incoming running-sum words.
- DATA_W, 32, width of recovered samples; ACC_W > DATA_W required.
- STOP_ON_ERR, 1: 1 = halt input acceptance after the first range error until rst or clr; 0 = flag and continue.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- clr  in  1  synchronous soft clear: zero lane history, return to LANE0, leave output register intact.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  ACC_W  running-sum word.
- out_valid  out  1  output register holds a sample.
- out_ready  in  1  downstream accepts the sample.
- out_lane  out  1  lane of the sample (0/1).
- out_data  out  DATA_W  recovered sample.
- out_err  out  1  difference did not fit in DATA_W.
- halted  out  1  high in HALT state.

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous, active-high.
- Register values after rst: prev0=0, prev1=0, state=LANE0, out_valid=0, out_lane=0, out_data=0, out_err=0, halted=0.
- States:
  - LANE0 accepts a lane-0 beat and goes to LANE1.
  - LANE1 accepts a lane-1 beat and goes to LANE0.
  - HALT accepts nothing.
- Accept condition: in_valid && in_ready.
- in_ready = (state != HALT) && (!out_valid || out_ready); no combinational path from in_valid to in_ready.
- On accept in lane L:
  - diff = in_data - prevL, computed modulo 2^ACC_W.
  - prevL <= in_data.
  - out_data <= diff[DATA_W-1:0].
  - out_err <= |diff[ACC_W-1:DATA_W].
  - out_lane <= L.
  - out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid. Full throughput of 1 beat/cycle when out_ready is held high.
- Output hold: when out_valid && !out_ready, out_data, out_lane and out_err hold stable and no input is accepted.
- Output drain: when out_valid && out_ready with no new accept in that cycle, out_valid <= 0 next cycle; data fields keep their last value.
- Wrap-around: a sum that wraps past 2^ACC_W-1 still yields the correct diff through modulo subtraction.
  - Example: prev=0xFF_FFFF_FFF0, in=0x00_0000_0010 gives diff=0x20 with err=0.
- Error handling:
  - With STOP_ON_ERR=1, an accepted beat with err=1 sends the next state to HALT; that erroneous sample is still presented on the output.
  - With STOP_ON_ERR=0, the lane alternation continues normally.
- HALT exits only on rst or clr. halted = (state == HALT).
- clr:
  - Zeros prev0 and prev1 and sets state=LANE0.
  - Has priority over a simultaneous accept: that beat is dropped and in_ready is forced low in the clr cycle.
  - A pending output sample stays valid until it is consumed.
- rst mid-operation discards any pending output, so out_valid=0 on the next cycle.

Optional Feature:
- Macro: ACCUM_DIFF_STATS_EN.
- When defined, adds two outputs:
  - beat_count, 16 bits: counts accepted beats; wraps at 0xFFFF to 0.
  - err_count, 8 bits: counts accepted beats with err=1; saturates at 0xFF.
- Both counters are zeroed by rst and by clr.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Basic decode: rst, then feed sums 5, 7, 12, 17 with out_ready=1 → outputs (lane0,5), (lane1,7), (lane0,7), (lane1,10), all err=0, each 1 cycle after its accept.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and the output stays stable; release → the next beat is accepted on the release cycle, so no beat is lost or duplicated.
- Wrap-around: lane0 prev=0xFF_FFFF_FFF0, next lane0 sum=0x00_0000_0010 → out_data=0x20, err=0.
- Range error with STOP_ON_ERR=1: lane0 sums 0 then 0x01_0000_0000 → out_err=1, halted=1, in_ready=0; then pulse clr → halted=0, state=LANE0, and the next beat is decoded against prev=0.
- clr collision: assert clr in the same cycle as in_valid → beat not accepted (in_ready=0); the following sums 3, 4 produce (lane0,3), (lane1,4).
- Mid-stream reset: assert rst while out_valid=1 and out_ready=0 → next cycle out_valid=0, out_err=0, prev0=prev1=0; with ACCUM_DIFF_STATS_EN defined, beat_count=0 and err_count=0.

Source files
------------

// File: rtl/accum_diff_split.sv
// accum_diff_split: two-lane running-sum differencer; ACCUM_DIFF_STATS_EN adds beat/err counters
module accum_diff_split #(
    parameter int ACC_W       = 40,
    parameter int DATA_W      = 32,
    parameter int STOP_ON_ERR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ACC_W-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_lane,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              halted
`ifdef ACCUM_DIFF_STATS_EN
    ,
    output logic [15:0]       beat_count,
    output logic [7:0]        err_count
`endif
);
    typedef enum logic [1:0] {LANE0, LANE1, HALT} state_t;
    state_t state_q, state_d;
    logic [ACC_W-1:0] prev0_q, prev0_d, prev1_q, prev1_d, diff;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_lane_q, out_lane_d, out_err_q, out_err_d;
    logic accept, lane, err;
`ifdef ACCUM_DIFF_STATS_EN
    logic [15:0] beat_count_q, beat_count_d;
    logic [7:0] err_count_q, err_count_d;
`endif
    always_comb begin
        lane = state_q == LANE1;
        in_ready = (state_q != HALT) && (!out_valid_q || out_ready) && !clr;
        accept = in_valid && in_ready;
        diff = in_data - (lane ? prev1_q : prev0_q);
        err = |diff[ACC_W-1:DATA_W];
        prev0_d = clr ? '0 : (accept && !lane) ? in_data : prev0_q;
        prev1_d = clr ? '0 : (accept && lane) ? in_data : prev1_q;
        state_d = clr ? LANE0 :
                  !accept ? state_q :
                  (err && STOP_ON_ERR != 0) ? HALT :
                  lane ? LANE0 : LANE1;
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_data_d = accept ? diff[DATA_W-1:0] : out_data_q;
        out_lane_d = accept ? lane : out_lane_q;
        out_err_d = accept ? err : out_err_q;
`ifdef ACCUM_DIFF_STATS_EN
        beat_count_d = clr ? '0 : accept ? beat_count_q + 16'd1 : beat_count_q;
        err_count_d = clr ? '0 : (accept && err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LANE0;
            prev0_q <= '0;
            prev1_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_lane_q <= 1'b0;
            out_err_q <= 1'b0;
`ifdef ACCUM_DIFF_STATS_EN
            beat_count_q <= '0;
            err_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            prev0_q <= prev0_d;
            prev1_q <= prev1_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_lane_q <= out_lane_d;
            out_err_q <= out_err_d;
`ifdef ACCUM_DIFF_STATS_EN
            beat_count_q <= beat_count_d;
            err_count_q <= err_count_d;
`endif
        end
    end
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_lane = out_lane_q;
    assign out_err = out_err_q;
    assign halted = state_q == HALT;
`ifdef ACCUM_DIFF_STATS_EN
    assign beat_count = beat_count_q;
    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_accum_diff_split.sv
// tb_accum_diff_split: vector table plus scoreboard bench for accum_diff_split
module tb_accum_diff_split;
    logic clk = 1'b0, rst, clr, in_valid, in_ready, out_valid, out_ready, out_lane, out_err, halted;
    logic [39:0] in_data;
    logic [31:0] out_data;
`ifdef ACCUM_DIFF_STATS_EN
    logic [15:0] beat_count;
    logic [7:0] err_count;
`endif
    int errors = 0, checks = 0;
    logic [33:0] q[$];
    typedef struct {logic [39:0] sum; logic lane; logic [31:0] data; logic err;} vec_t;
    vec_t tbl[4];

    accum_diff_split dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_data(out_data), .out_err(out_err), .halted(halted)
`ifdef ACCUM_DIFF_STATS_EN
        , .beat_count(beat_count), .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // every handshake seen at the falling edge must match the oldest expected sample
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", {out_lane, out_data, out_err}, 64'hDEAD);
            else chk("out", {out_lane, out_data, out_err}, q.pop_front());
        end
    end

    task automatic send(input logic [39:0] s, input logic el, input logic [31:0] ed, input logic ee);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data = s;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
        else begin
            q.push_back({el, ed, ee});
            chk("lat_valid", out_valid, 1);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        #1 chk("drain", q.size(), 0);
    endtask

    initial begin
        tbl[0] = '{40'd5, 1'b0, 32'd5, 1'b0};
        tbl[1] = '{40'd7, 1'b1, 32'd7, 1'b0};
        tbl[2] = '{40'd12, 1'b0, 32'd7, 1'b0};
        tbl[3] = '{40'd17, 1'b1, 32'd10, 1'b0};
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out", {out_valid, out_lane, out_data, out_err, halted}, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef ACCUM_DIFF_STATS_EN
        chk("rst_counts", {beat_count, err_count}, 0);
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send(tbl[i].sum, tbl[i].lane, tbl[i].data, tbl[i].err);
        drain();
`ifdef ACCUM_DIFF_STATS_EN
        chk("beat_count", beat_count, 4);
`endif
        // backpressure: A waits in the output register while B is held off
        out_ready = 1'b0;
        send(40'd20, 1'b0, 32'd8, 1'b0);
        in_valid = 1'b1; in_data = 40'd30;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold", {out_valid, out_lane, out_data, out_err}, {1'b1, 1'b0, 32'd8, 1'b0});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        q.push_back({1'b1, 32'd13, 1'b0});
        drain();
        // clr collides with a valid beat
        clr = 1'b1; in_valid = 1'b1; in_data = 40'd99;
        @(negedge clk);
        chk("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1 clr = 1'b0; in_valid = 1'b0;
        send(40'd3, 1'b0, 32'd3, 1'b0);
        send(40'd4, 1'b1, 32'd4, 1'b0);
        drain();
        // climb lane 0 to just below 2^40, then wrap
        do_clr();
        for (int i = 1; i <= 256; i++) begin
            send(40'(i) * 40'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0);
            send(40'd0, 1'b1, 32'd0, 1'b0);
        end
        send(40'hFF_FFFF_FFF0, 1'b0, 32'hF0, 1'b0);
        send(40'd0, 1'b1, 32'd0, 1'b0);
        send(40'h10, 1'b0, 32'h20, 1'b0);
        drain();
        // range error halts the block until clr
        do_clr();
        send(40'd0, 1'b0, 32'd0, 1'b0);
        send(40'd0, 1'b1, 32'd0, 1'b0);
        send(40'h1_0000_0000, 1'b0, 32'd0, 1'b1);
        chk("err_halted", halted, 1);
        in_valid = 1'b1; in_data = 40'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();
`ifdef ACCUM_DIFF_STATS_EN
        chk("err_count", err_count, 1);
`endif
        do_clr();
        chk("clr_halted", halted, 0);
        send(40'd9, 1'b0, 32'd9, 1'b0);
        send(40'd4, 1'b1, 32'd4, 1'b0);
        drain();
        // reset while an erroneous sample is stalled
        out_ready = 1'b0;
        send(40'h1_0000_0009, 1'b0, 32'd0, 1'b1);
        chk("stall_err", {out_valid, out_err, halted}, 3'b111);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q.delete();
        chk("mid_rst", {out_valid, out_err, halted}, 0);
`ifdef ACCUM_DIFF_STATS_EN
        chk("mid_rst_counts", {beat_count, err_count}, 0);
`endif
        out_ready = 1'b1;
        send(40'd6, 1'b0, 32'd6, 1'b0);
        send(40'd8, 1'b1, 32'd8, 1'b0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
